cnn_conv_ctrl: RTL and testbench

Streaming 3x3 convolution engine for 8-bit greyscale frames, LINE_WIDTH x IMG_HEIGHT, raster order.
- Line buffers build the sliding window; a 9-tap MAC applies the programmable kernel; the result is normalised and clamped to 8 bits.
- Results are queued in an internal output FIFO with a ready/valid master port.
- Input back-pressure is derived from FIFO prog-full.
- Sits between the DMA input stream and the DMA output stream of the SSL accelerator.

---
 rtl/cnn_conv_ctrl_if.sv | 11 +
 rtl/cnn_conv_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cnn_conv_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cnn_conv_ctrl_if.sv
// Ready/valid stream bundle for the convolution engine: pixel input (slave side) and result output (master side).
interface cnn_conv_ctrl_if #(
  parameter int unsigned DW = 8
);
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/cnn_conv_ctrl.sv
// Streaming 3x3 convolution over raster-order 8-bit frames with an output FWFT FIFO.
// Optional build macro CNN_ROUND_EN: round-half-up before the normalising shift.
module cnn_conv_ctrl #(
  parameter int unsigned DATA_RES         = 8,
  parameter int unsigned WEIGHT_RES       = 8,
  parameter int unsigned LINE_WIDTH       = 28,
  parameter int unsigned IMG_HEIGHT       = 28,
  parameter int unsigned KERNEL_WIDTH     = 3,
  parameter int unsigned KERNEL_SIZE      = 9,
  parameter int unsigned NORM_SHIFT       = 4,
  parameter int unsigned FIFO_DEPTH       = 16,
  parameter int unsigned PROG_FULL_THRESH = 12
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  cnn_conv_ctrl_if.slave                      pix_if,
  input  logic [WEIGHT_RES*KERNEL_SIZE-1:0]   kernel_i,
  output logic [DATA_RES-1:0]                 pixel_o,
  output logic                                data_valid_o,
  output logic                                pixel_valid_o,
  cnn_conv_ctrl_if.master                     m_if,
  output logic                                prog_full_o,
  output logic                                overflow_o
);

  localparam int unsigned LB_LEN = 2 * LINE_WIDTH + KERNEL_WIDTH;
  localparam int unsigned COL_W  = $clog2(LINE_WIDTH);
  localparam int unsigned ROW_W  = $clog2(IMG_HEIGHT);
  localparam int unsigned PROD_W = DATA_RES + WEIGHT_RES + 1;
  localparam int unsigned SUM_W  = PROD_W + $clog2(KERNEL_SIZE);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << DATA_RES) - 1);

  // Age of window tap k in the line buffer (index 0 = newest pixel).
  function automatic int unsigned tap_idx(input int unsigned k);
    return (KERNEL_WIDTH - 1 - k / KERNEL_WIDTH) * LINE_WIDTH
         + (KERNEL_WIDTH - 1 - k % KERNEL_WIDTH);
  endfunction

  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [DATA_RES-1:0] lb_q [LB_LEN];
  logic                vld1_q, pv_q;
  logic [DATA_RES-1:0] pix_q;
  logic                accept_c, win_valid_c;

  assign accept_c    = pix_if.valid && pix_if.ready;
  assign win_valid_c = accept_c && (row_q >= ROW_W'(KERNEL_WIDTH - 1))
                                && (col_q >= COL_W'(KERNEL_WIDTH - 1));

  // Raster position of the pixel currently offered.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept_c) begin
      if (col_q == COL_W'(LINE_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffer needs no reset: the row counter gates every window it feeds.
  always_ff @(posedge clk_i) begin
    if (accept_c) begin
      lb_q[0] <= pix_if.data;
      for (int i = 1; i < LB_LEN; i++) lb_q[i] <= lb_q[i-1];
    end
  end

  logic signed [DATA_RES:0]     px_s  [KERNEL_SIZE];
  logic signed [WEIGHT_RES-1:0] w_s   [KERNEL_SIZE];
  logic signed [PROD_W-1:0]     prod  [KERNEL_SIZE];
  logic signed [SUM_W-1:0]      sum_c, biased_c, shifted_c;
  logic [DATA_RES-1:0]          clamp_c;

  // MAC runs in the cycle after the completing pixel, while lb_q holds that window.
  always_comb begin
    sum_c = '0;
    for (int unsigned k = 0; k < KERNEL_SIZE; k++) begin
      px_s[k] = {1'b0, lb_q[tap_idx(k)]};
      w_s[k]  = kernel_i[k*WEIGHT_RES +: WEIGHT_RES];
      prod[k] = PROD_W'(px_s[k]) * PROD_W'(w_s[k]);
      sum_c   = sum_c + SUM_W'(prod[k]);
    end
  end

`ifdef CNN_ROUND_EN
  localparam int unsigned ROUND_BIAS = 1 << (NORM_SHIFT - 1);
  assign biased_c = sum_c + SUM_W'(ROUND_BIAS);
`else
  assign biased_c = sum_c;
`endif

  assign shifted_c = biased_c >>> NORM_SHIFT;

  always_comb begin
    clamp_c = DATA_RES'(shifted_c);
    if (shifted_c[SUM_W-1])        clamp_c = '0;
    else if (shifted_c > PIX_MAX)  clamp_c = '1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld1_q <= 1'b0;
      pv_q   <= 1'b0;
      pix_q  <= '0;
    end else begin
      vld1_q <= win_valid_c;
      pv_q   <= vld1_q;
      if (vld1_q) pix_q <= clamp_c;
    end
  end

  assign data_valid_o  = vld1_q;
  assign pixel_valid_o = pv_q;
  assign pixel_o       = pix_q;

  logic [DATA_RES-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q;
  logic                full_c, pop_c, wr_en_c;

  assign full_c  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop_c   = m_if.valid && m_if.ready;
  // A push into a full FIFO is kept only when the head leaves in the same cycle.
  assign wr_en_c = pv_q && (!full_c || pop_c);

  always_comb begin
    count_d = count_q;
    if (wr_en_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (!wr_en_c && pop_c) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= pix_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      overflow_q <= overflow_q | (pv_q && full_c && !pop_c);
    end
  end

  assign m_if.valid   = (count_q != '0);
  assign m_if.data    = m_if.valid ? mem_q[rd_ptr_q] : '0;
  assign prog_full_o  = (count_q >= CNT_W'(PROG_FULL_THRESH));
  assign pix_if.ready = !prog_full_o;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_cnn_conv_ctrl.sv
// Directed bench for cnn_conv_ctrl; expected results are hand-derived per kernel/frame pattern.
module tb_cnn_conv_ctrl;
  localparam int NOUT = 676;

  logic        clk = 1'b0;
  logic        reset;
  logic [71:0] kernel;
  logic [7:0]  pixel_o;
  logic        data_valid_o, pixel_valid_o, prog_full_o, overflow_o;

  cnn_conv_ctrl_if #(.DW(8)) pix_if();
  cnn_conv_ctrl_if #(.DW(8)) m_if();

  cnn_conv_ctrl dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .pix_if        (pix_if),
    .kernel_i      (kernel),
    .pixel_o       (pixel_o),
    .data_valid_o  (data_valid_o),
    .pixel_valid_o (pixel_valid_o),
    .m_if          (m_if),
    .prog_full_o   (prog_full_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  localparam logic [71:0] K_GAUSS  = {8'd1, 8'd2, 8'd1, 8'd2, 8'd4, 8'd2, 8'd1, 8'd2, 8'd1};
  localparam logic [71:0] K_NEG1   = {9{8'hFF}};
  localparam logic [71:0] K_127    = {9{8'h7F}};
  localparam logic [71:0] K_CENTRE = {32'h0, 8'd24, 32'h0};

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int exp_mode = 0;
  logic [7:0] exp_val = 8'd0;
  logic [7:0] exp_now;
  int out_idx = 0;
  int acc_cnt = 0;
  int acc59_cyc = -1;
  int first_pv_cyc = -1, first_dv_cyc = -1;
  bit bp_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output-side scoreboard: every pop is checked in order.
  always @(negedge clk) begin
    if (mon_en && m_if.valid && m_if.ready) begin
      exp_now = (exp_mode == 1) ? 8'((out_idx % 26) + 1) : exp_val;
      check("out_data", 32'(m_if.data), 32'(exp_now));
      out_idx++;
    end
    if (pixel_valid_o && first_pv_cyc < 0) first_pv_cyc = cyc;
    if (data_valid_o && first_dv_cyc < 0) first_dv_cyc = cyc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_px(input logic [7:0] p);
    int guard = 0;
    pix_if.data  = p;
    pix_if.valid = 1'b1;
    while (!pix_if.ready && guard < 2000) begin
      if (bp_hold) begin
        repeat (8) step();
        check("bp_prog_full", 32'(prog_full_o), 1);
        check("bp_ready",     32'(pix_if.ready), 0);
        check("bp_tvalid",    32'(m_if.valid), 1);
        check("bp_head",      32'(m_if.data), 1);
        check("bp_accepted",  32'(acc_cnt), 72);
        check("bp_overflow",  32'(overflow_o), 0);
        m_if.ready = 1'b1;
        bp_hold    = 1'b0;
      end else begin
        step();
        guard++;
      end
    end
    if (!pix_if.ready) check("push_timeout", 32'(pix_if.ready), 1);
    acc_cnt++;
    if (acc_cnt == 59) acc59_cyc = cyc;
    step();
  endtask

  task automatic send_frame(input int col_mode, input logic [7:0] val);
    acc_cnt = 0;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        push_px(col_mode != 0 ? 8'(c) : val);
    pix_if.valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int guard = 0;
    while (out_idx < NOUT && guard < 4000) begin
      step();
      guard++;
    end
    repeat (4) step();
    check({tag, "_count"},    32'(out_idx), 32'(NOUT));
    check({tag, "_overflow"}, 32'(overflow_o), 0);
    check({tag, "_drained"},  32'(m_if.valid), 0);
  endtask

  task automatic start_test(input int mode, input logic [7:0] val, input logic [71:0] k);
    kernel   = k;
    exp_mode = mode;
    exp_val  = val;
    out_idx  = 0;
    mon_en   = 1'b1;
  endtask

  initial begin
    reset        = 1'b1;
    kernel       = K_GAUSS;
    pix_if.data  = 8'd0;
    pix_if.valid = 1'b0;
    m_if.ready   = 1'b1;
    repeat (3) step();
    check("rst_data_valid",  32'(data_valid_o), 0);
    check("rst_pixel_valid", 32'(pixel_valid_o), 0);
    check("rst_pixel",       32'(pixel_o), 0);
    check("rst_tvalid",      32'(m_if.valid), 0);
    check("rst_tdata",       32'(m_if.data), 0);
    check("rst_prog_full",   32'(prog_full_o), 0);
    check("rst_overflow",    32'(overflow_o), 0);
    check("rst_ready",       32'(pix_if.ready), 1);
    reset = 1'b0;
    step();

    // Gaussian over a flat field reproduces the field.
    start_test(0, 8'd100, K_GAUSS);
    send_frame(0, 8'd100);
    wait_out("gauss_flat");

    // Gaussian over a column ramp gives C-1; also measure first-output latency.
    first_pv_cyc = -1;
    first_dv_cyc = -1;
    start_test(1, 8'd0, K_GAUSS);
    send_frame(1, 8'd0);
    check("lat_data_valid",  32'(first_dv_cyc - acc59_cyc), 1);
    check("lat_pixel_valid", 32'(first_pv_cyc - acc59_cyc), 2);
    wait_out("gauss_ramp");

    // Negative sum clamps to 0.
    start_test(0, 8'd0, K_NEG1);
    send_frame(0, 8'd10);
    wait_out("clamp_low");

    // Large positive sum clamps to 255.
    start_test(0, 8'd255, K_127);
    send_frame(0, 8'd255);
    wait_out("clamp_high");

    // Sum 24: truncation gives 1, round-half-up gives 2.
`ifdef CNN_ROUND_EN
    start_test(0, 8'd2, K_CENTRE);
`else
    start_test(0, 8'd1, K_CENTRE);
`endif
    send_frame(0, 8'd1);
    wait_out("norm_24");

    // Downstream stall: input throttles via prog_full, then everything drains in order.
    start_test(1, 8'd0, K_GAUSS);
    m_if.ready = 1'b0;
    bp_hold    = 1'b1;
    send_frame(1, 8'd0);
    check("bp_released", 32'(bp_hold), 0);
    wait_out("backpressure");

    // Reset part-way through a frame, then a clean frame.
    mon_en = 1'b0;
    kernel = K_GAUSS;
    acc_cnt = 0;
    for (int i = 0; i < 300; i++) push_px(8'd100);
    pix_if.valid = 1'b0;
    reset = 1'b1;
    step();
    check("mid_rst_data_valid",  32'(data_valid_o), 0);
    check("mid_rst_pixel_valid", 32'(pixel_valid_o), 0);
    check("mid_rst_pixel",       32'(pixel_o), 0);
    check("mid_rst_tvalid",      32'(m_if.valid), 0);
    check("mid_rst_prog_full",   32'(prog_full_o), 0);
    reset = 1'b0;
    step();
    check("mid_rst_ready", 32'(pix_if.ready), 1);
    start_test(0, 8'd50, K_GAUSS);
    send_frame(0, 8'd50);
    wait_out("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
